// File: rtl/vcve2_vec_ex_sequencer.sv
// vcve2_vec_ex_sequencer: issue-side sequencer for the vector execution path.
// Takes one vector arithmetic request, then walks the destination register a
// 32-bit word at a time: read sources, run the execution block, write back
// with tail byte-enables.
// Optional feature macro: VCVE2_VSEQ_SCALAR_EN (scalar operand B, SEW splat).

package vcve2_vseq_pkg;
   typedef enum logic [5:0] {
      ALU_ADD = 6'd0, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL,
      ALU_SRA, ALU_MUL, ALU_MAC, ALU_NMSAC, ALU_MADD, ALU_NMSUB
   } alu_op_e;
endpackage

module vcve2_vec_ex_sequencer
   import vcve2_vseq_pkg::*;
#(
   parameter  int unsigned VLEN = 128,
   localparam int unsigned WPR  = VLEN / 32,
   localparam int unsigned WIW  = $clog2(WPR),
   localparam int unsigned VLW  = $clog2(VLEN / 8) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  alu_op_e          req_op_i,
   input  logic [2:0]       req_vsew_i,
   input  logic [VLW-1:0]   req_vl_i,
   input  logic [4:0]       req_vs1_i,
   input  logic [4:0]       req_vs2_i,
   input  logic [4:0]       req_vd_i,
   input  logic             req_vx_i,
   input  logic [31:0]      req_scalar_i,
   input  logic             flush_i,
   output logic [5+WIW-1:0] vrf_raddr_a_o,
   output logic [5+WIW-1:0] vrf_raddr_b_o,
   input  logic [31:0]      vrf_rdata_a_i,
   input  logic [31:0]      vrf_rdata_b_i,
   output logic             vrf_we_o,
   output logic [5+WIW-1:0] vrf_waddr_o,
   output logic [31:0]      vrf_wdata_o,
   output logic [3:0]       vrf_wbe_o,
   output alu_op_e          ex_operator_o,
   output logic [31:0]      ex_operand_a_o,
   output logic [31:0]      ex_operand_b_o,
   output logic [31:0]      ex_operand_c_o,
   output logic [2:0]       ex_vsew_o,
   output logic             ex_vec_instr_o,
   output logic             ex_first_cycle_o,
   input  logic             ex_valid_i,
   input  logic [31:0]      ex_result_i,
   output logic             done_o,
   output logic             illegal_o
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_EXEC, S_WB, S_DONE} state_e;

   state_e         state_q, state_d;
   alu_op_e        op_q;
   logic [2:0]     vsew_q;
   logic [4:0]     vs1_q, vs2_q, vd_q;
   logic [VLW-1:0] nbytes_q, nwords_q;
   logic [WIW-1:0] widx_q;
   logic           illegal_q, first_q;
   logic [31:0]    opa_q, opb_q, opc_q, opc_pre_q, res_q;

   logic           accept;
   logic [VLW-1:0] max_vl, vl_eff, nbytes, nwords;
   logic [VLW-1:0] widx_ext, rem;
   logic           last_word;
   logic [3:0]     wbe_calc;
   logic [31:0]    opb_src;
   logic           use_b_port;

   assign accept = req_valid_i && (state_q == S_IDLE);

   // Request decode: clamp vl to the register capacity at this SEW, derive
   // byte and word counts. Reserved SEW gives zero capacity, hence no words.
   always_comb begin
      max_vl = '0;
      nbytes = '0;
      case (req_vsew_i)
         3'd0:    max_vl = VLW'(VLEN / 8);
         3'd1:    max_vl = VLW'(VLEN / 16);
         3'd2:    max_vl = VLW'(VLEN / 32);
         default: max_vl = '0;
      endcase
      vl_eff = (req_vl_i < max_vl) ? req_vl_i : max_vl;
      case (req_vsew_i)
         3'd0:    nbytes = vl_eff;
         3'd1:    nbytes = vl_eff << 1;
         3'd2:    nbytes = vl_eff << 2;
         default: nbytes = '0;
      endcase
      nwords = (nbytes + VLW'(3)) >> 2;
   end

   // Tail handling: the last word keeps only the bytes still inside vl.
   assign widx_ext  = {{(VLW-WIW){1'b0}}, widx_q};
   assign last_word = (widx_ext == nwords_q - VLW'(1));
   assign rem       = nbytes_q - {1'b0, widx_q, 2'b00};

   // Byte-enable for the word being written back.
   always_comb begin
      wbe_calc = 4'hF;
      if (last_word && rem < VLW'(4)) begin
         case (rem[1:0])
            2'd1:    wbe_calc = 4'h1;
            2'd2:    wbe_calc = 4'h3;
            2'd3:    wbe_calc = 4'h7;
            default: wbe_calc = 4'hF;
         endcase
      end
   end

`ifdef VCVE2_VSEQ_SCALAR_EN
   logic        vx_q;
   logic [31:0] scalar_q, splat;

   // Scalar operand fields, latched with the rest of the request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vx_q     <= 1'b0;
         scalar_q <= '0;
      end else if (accept) begin
         vx_q     <= req_vx_i;
         scalar_q <= req_scalar_i;
      end
   end

   // Replicate the scalar across every element of the word.
   always_comb begin
      case (vsew_q)
         3'd0:    splat = {4{scalar_q[7:0]}};
         3'd1:    splat = {2{scalar_q[15:0]}};
         default: splat = scalar_q;
      endcase
   end

   assign opb_src    = vx_q ? splat : vrf_rdata_b_i;
   assign use_b_port = !vx_q;
`else
   logic unused_scalar;
   assign unused_scalar = ^{req_vx_i, req_scalar_i};
   assign opb_src       = vrf_rdata_b_i;
   assign use_b_port    = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and all handshake/port outputs.
   always_comb begin
      state_d          = state_q;
      req_ready_o      = (state_q == S_IDLE);
      vrf_raddr_a_o    = '0;
      vrf_raddr_b_o    = '0;
      vrf_we_o         = 1'b0;
      vrf_waddr_o      = '0;
      vrf_wdata_o      = '0;
      vrf_wbe_o        = '0;
      ex_operator_o    = ALU_ADD;
      ex_operand_a_o   = '0;
      ex_operand_b_o   = '0;
      ex_operand_c_o   = '0;
      ex_vsew_o        = '0;
      ex_vec_instr_o   = 1'b0;
      ex_first_cycle_o = 1'b0;
      done_o           = 1'b0;
      illegal_o        = 1'b0;

      if (state_q != S_IDLE) begin
         ex_operator_o  = op_q;
         ex_operand_a_o = opa_q;
         ex_operand_b_o = opb_q;
         ex_operand_c_o = opc_q;
         ex_vsew_o      = vsew_q;
      end

      case (state_q)
         S_IDLE: begin
            // Only the accept cycle drives port A: it prefetches vd word 0.
            if (req_valid_i) vrf_raddr_a_o = {req_vd_i, {WIW{1'b0}}};
            if (accept) state_d = (nwords == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            vrf_raddr_a_o = {vs2_q, widx_q};
            if (use_b_port) vrf_raddr_b_o = {vs1_q, widx_q};
            state_d = S_EXEC;
         end
         S_EXEC: begin
            ex_vec_instr_o   = 1'b1;
            ex_first_cycle_o = first_q;
            if (ex_valid_i) state_d = S_WB;
         end
         S_WB: begin
            // Port A is free here, so it prefetches the next vd word.
            vrf_raddr_a_o = {vd_q, widx_q + WIW'(1)};
            vrf_we_o      = !flush_i;
            vrf_waddr_o   = {vd_q, widx_q};
            vrf_wdata_o   = res_q;
            vrf_wbe_o     = wbe_calc;
            state_d       = last_word ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done_o    = !flush_i;
            illegal_o = !flush_i && illegal_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
   end

   // Request latch, word index, operand and result registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q      <= ALU_ADD;
         vsew_q    <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         vd_q      <= '0;
         nbytes_q  <= '0;
         nwords_q  <= '0;
         widx_q    <= '0;
         illegal_q <= 1'b0;
         first_q   <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         opc_q     <= '0;
         opc_pre_q <= '0;
         res_q     <= '0;
      end else begin
         first_q <= (state_q == S_ISSUE);
         case (state_q)
            S_IDLE: if (accept) begin
               op_q      <= req_op_i;
               vsew_q    <= req_vsew_i;
               vs1_q     <= req_vs1_i;
               vs2_q     <= req_vs2_i;
               vd_q      <= req_vd_i;
               nbytes_q  <= nbytes;
               nwords_q  <= nwords;
               widx_q    <= '0;
               illegal_q <= (req_vsew_i > 3'd2);
               opc_pre_q <= vrf_rdata_a_i;
            end
            S_ISSUE: begin
               opa_q <= vrf_rdata_a_i;
               opb_q <= opb_src;
               opc_q <= opc_pre_q;
            end
            S_EXEC: if (ex_valid_i) res_q <= ex_result_i;
            S_WB: begin
               widx_q    <= widx_q + WIW'(1);
               opc_pre_q <= vrf_rdata_a_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vcve2_vec_ex_sequencer.sv
// Directed bench for vcve2_vec_ex_sequencer (VLEN=128). A static register
// file model feeds reads; a responder raises ex_valid after `stall` EXEC
// cycles and returns (a+b)^c so the written data reflects all three operands.
module tb_vcve2_vec_ex_sequencer;
   import vcve2_vseq_pkg::*;

   localparam int VLEN = 128;
   localparam int WPR  = 4;
   localparam int WIW  = 2;
   localparam int VLW  = 5;
   localparam int AW   = 5 + WIW;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid_i, req_ready_o;
   alu_op_e        req_op_i;
   logic [2:0]     req_vsew_i;
   logic [VLW-1:0] req_vl_i;
   logic [4:0]     req_vs1_i, req_vs2_i, req_vd_i;
   logic           req_vx_i;
   logic [31:0]    req_scalar_i;
   logic           flush_i;
   logic [AW-1:0]  vrf_raddr_a_o, vrf_raddr_b_o, vrf_waddr_o;
   logic [31:0]    vrf_rdata_a_i, vrf_rdata_b_i, vrf_wdata_o;
   logic           vrf_we_o;
   logic [3:0]     vrf_wbe_o;
   alu_op_e        ex_operator_o;
   logic [31:0]    ex_operand_a_o, ex_operand_b_o, ex_operand_c_o;
   logic [2:0]     ex_vsew_o;
   logic           ex_vec_instr_o, ex_first_cycle_o, ex_valid_i;
   logic [31:0]    ex_result_i;
   logic           done_o, illegal_o;

   vcve2_vec_ex_sequencer #(.VLEN(VLEN)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_vsew_i(req_vsew_i), .req_vl_i(req_vl_i), .req_vs1_i(req_vs1_i),
      .req_vs2_i(req_vs2_i), .req_vd_i(req_vd_i), .req_vx_i(req_vx_i),
      .req_scalar_i(req_scalar_i), .flush_i(flush_i),
      .vrf_raddr_a_o(vrf_raddr_a_o), .vrf_raddr_b_o(vrf_raddr_b_o),
      .vrf_rdata_a_i(vrf_rdata_a_i), .vrf_rdata_b_i(vrf_rdata_b_i),
      .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
      .vrf_wbe_o(vrf_wbe_o), .ex_operator_o(ex_operator_o),
      .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
      .ex_operand_c_o(ex_operand_c_o), .ex_vsew_o(ex_vsew_o),
      .ex_vec_instr_o(ex_vec_instr_o), .ex_first_cycle_o(ex_first_cycle_o),
      .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
      .done_o(done_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   // Register file model, combinational read.
   logic [31:0] vrf [32][WPR];
   assign vrf_rdata_a_i = vrf[vrf_raddr_a_o[AW-1:WIW]][vrf_raddr_a_o[WIW-1:0]];
   assign vrf_rdata_b_i = vrf[vrf_raddr_b_o[AW-1:WIW]][vrf_raddr_b_o[WIW-1:0]];

   // Execution block responder.
   int stall = 1;
   int ex_cnt = 0;
   always @(posedge clk) ex_cnt <= ex_vec_instr_o ? ex_cnt + 1 : 0;
   assign ex_valid_i  = ex_vec_instr_o && (ex_cnt == stall - 1);
   assign ex_result_i = (ex_operand_a_o + ex_operand_b_o) ^ ex_operand_c_o;

   // Monitor: write log, done/illegal counts, accept and done cycle stamps.
   int cyc = 0, wr_n = 0, done_n = 0, ill_n = 0, acc_cyc = 0, done_cyc = 0;
   logic [AW-1:0] wr_addr [64];
   logic [31:0]   wr_data [64];
   logic [3:0]    wr_be   [64];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (req_valid_i && req_ready_o) acc_cyc <= cyc;
         if (vrf_we_o) begin
            if (wr_n < 64) begin
               wr_addr[wr_n] <= vrf_waddr_o;
               wr_data[wr_n] <= vrf_wdata_o;
               wr_be[wr_n]   <= vrf_wbe_o;
            end
            wr_n <= wr_n + 1;
         end
         if (done_o) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
         end
         if (illegal_o) ill_n <= ill_n + 1;
      end
   end

   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request at the current negedge; returns one cycle later.
   task automatic send(input alu_op_e op, input logic [2:0] sew, input logic [VLW-1:0] vl,
                       input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                       input logic vx, input logic [31:0] sc);
      req_op_i = op; req_vsew_i = sew; req_vl_i = vl;
      req_vs1_i = vs1; req_vs2_i = vs2; req_vd_i = vd;
      req_vx_i = vx; req_scalar_i = sc; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k = 0;
      while (done_n == d0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(done_n), 32'(d0 + 1));
   endtask

   initial begin
      int wb, d0, k;
      rst = 1'b1; req_valid_i = 1'b0; req_op_i = ALU_ADD; req_vsew_i = '0;
      req_vl_i = '0; req_vs1_i = '0; req_vs2_i = '0; req_vd_i = '0;
      req_vx_i = 1'b0; req_scalar_i = '0; flush_i = 1'b0;
      for (int r = 0; r < 32; r++)
         for (int w = 0; w < WPR; w++) vrf[r][w] = '0;
      vrf[1][0] = 32'h01010101;
      vrf[2][0] = 32'h01020304;
      vrf[3][0] = 32'h000000F0;
      vrf[4][0] = 32'h11111111; vrf[4][1] = 32'h22222222;
      vrf[4][2] = 32'h33333333; vrf[4][3] = 32'h44444444;
      for (int w = 0; w < WPR; w++) vrf[5][w] = 32'h01000001;
      vrf[6][1] = 32'h0000FF00;
      vrf[6][2] = 32'hFFFFFFFF;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_illegal", 32'(illegal_o), 32'd0);
      check("rst_we", 32'(vrf_we_o), 32'd0);
      check("rst_raddr_a", 32'(vrf_raddr_a_o), 32'd0);
      check("rst_opa", ex_operand_a_o, 32'd0);
      check("rst_first", 32'(ex_first_cycle_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single word: vl=4, SEW8
      send(ALU_MAC, 3'd0, 5'd4, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
      check("t1_ready_busy", 32'(req_ready_o), 32'd0);
      check("t1_raddr_a", 32'(vrf_raddr_a_o), 32'h08);
      check("t1_raddr_b", 32'(vrf_raddr_b_o), 32'h04);
      @(negedge clk);
      check("t1_first", 32'(ex_first_cycle_o), 32'd1);
      check("t1_vec", 32'(ex_vec_instr_o), 32'd1);
      check("t1_opa", ex_operand_a_o, 32'h01020304);
      check("t1_opb", ex_operand_b_o, 32'h01010101);
      check("t1_opc", ex_operand_c_o, 32'h000000F0);
      check("t1_op", 32'(ex_operator_o), 32'(ALU_MAC));
      check("t1_vsew", 32'(ex_vsew_o), 32'd0);
      @(negedge clk);
      check("t1_we", 32'(vrf_we_o), 32'd1);
      check("t1_waddr", 32'(vrf_waddr_o), 32'h0C);
      check("t1_wdata", vrf_wdata_o, 32'h020304F5);
      check("t1_wbe", 32'(vrf_wbe_o), 32'hF);
      @(negedge clk);
      check("t1_done", 32'(done_o), 32'd1);
      check("t1_illegal", 32'(illegal_o), 32'd0);
      @(negedge clk);
      check("t1_ready_after", 32'(req_ready_o), 32'd1);
      check("t1_latency", 32'(done_cyc - acc_cyc), 32'd4);

      // Tail: vl=5, SEW16 -> 10 bytes, 3 words, last be=3
      wb = wr_n; d0 = done_n;
      send(ALU_ADD, 3'd1, 5'd5, 5'd5, 5'd4, 5'd6, 1'b0, 32'h0);
      wait_done(d0, "t2_done_seen");
      repeat (2) @(negedge clk);
      check("t2_done_once", 32'(done_n), 32'(d0 + 1));
      check("t2_nwr", 32'(wr_n - wb), 32'd3);
      check("t2_addr0", 32'(wr_addr[wb]), 32'h18);
      check("t2_addr1", 32'(wr_addr[wb+1]), 32'h19);
      check("t2_addr2", 32'(wr_addr[wb+2]), 32'h1A);
      check("t2_be0", 32'(wr_be[wb]), 32'hF);
      check("t2_be1", 32'(wr_be[wb+1]), 32'hF);
      check("t2_be2", 32'(wr_be[wb+2]), 32'h3);
      check("t2_data0", wr_data[wb], 32'h12111112);
      check("t2_data1", wr_data[wb+1], 32'h2322DD23);
      check("t2_data2", wr_data[wb+2], 32'hCBCCCCCB);
      check("t2_latency", 32'(done_cyc - acc_cyc), 32'd10);

      // Clamp and stall: vl=31, SEW32 -> 4 words, 3-cycle EXEC each
      stall = 3; wb = wr_n; d0 = done_n;
      send(ALU_ADD, 3'd2, 5'd31, 5'd5, 5'd4, 5'd7, 1'b0, 32'h0);
      @(negedge clk);
      check("t3_first", 32'(ex_first_cycle_o), 32'd1);
      @(negedge clk);
      check("t3_first_only_once", 32'(ex_first_cycle_o), 32'd0);
      check("t3_vec_held", 32'(ex_vec_instr_o), 32'd1);
      wait_done(d0, "t3_done_seen");
      check("t3_nwr", 32'(wr_n - wb), 32'd4);
      check("t3_data0", wr_data[wb], 32'h12111112);
      check("t3_addr3", 32'(wr_addr[wb+3]), 32'h1F);
      check("t3_data3", wr_data[wb+3], 32'h45444445);
      check("t3_be3", 32'(wr_be[wb+3]), 32'hF);
      check("t3_latency", 32'(done_cyc - acc_cyc), 32'd21);
      stall = 1;

      // Flush during WB of word 1
      wb = wr_n; d0 = done_n;
      send(ALU_ADD, 3'd1, 5'd5, 5'd5, 5'd4, 5'd6, 1'b0, 32'h0);
      k = 0;
      while (!(vrf_we_o && vrf_waddr_o == 7'h19) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t4_reach_wb1", 32'(vrf_waddr_o), 32'h19);
      flush_i = 1'b1;
      #1;
      check("t4_we_suppressed", 32'(vrf_we_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      check("t4_ready", 32'(req_ready_o), 32'd1);
      repeat (3) @(negedge clk);
      check("t4_nwr", 32'(wr_n - wb), 32'd1);
      check("t4_no_done", 32'(done_n), 32'(d0));

      // Reserved SEW: done and illegal one cycle after accept, no writes
      wb = wr_n; d0 = ill_n;
      send(ALU_ADD, 3'd3, 5'd4, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
      check("t5_done", 32'(done_o), 32'd1);
      check("t5_illegal", 32'(illegal_o), 32'd1);
      @(negedge clk);
      check("t5_latency", 32'(done_cyc - acc_cyc), 32'd1);
      check("t5_ill_cnt", 32'(ill_n), 32'(d0 + 1));
      check("t5_ready", 32'(req_ready_o), 32'd1);

      // vl=0: done only
      send(ALU_ADD, 3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
      check("t6_done", 32'(done_o), 32'd1);
      check("t6_illegal", 32'(illegal_o), 32'd0);
      @(negedge clk);
      check("t6_nwr", 32'(wr_n - wb), 32'd0);

      // Scalar operand B
      d0 = done_n;
      send(ALU_ADD, 3'd0, 5'd4, 5'd1, 5'd2, 5'd3, 1'b1, 32'h000000AB);
`ifdef VCVE2_VSEQ_SCALAR_EN
      check("t7_raddr_b", 32'(vrf_raddr_b_o), 32'h00);
      @(negedge clk);
      check("t7_opb", ex_operand_b_o, 32'hABABABAB);
`else
      check("t7_raddr_b", 32'(vrf_raddr_b_o), 32'h04);
      @(negedge clk);
      check("t7_opb", ex_operand_b_o, 32'h01010101);
`endif
      wait_done(d0, "t7_done_seen");

      // Asynchronous reset in the middle of EXEC
      stall = 3; wb = wr_n; d0 = done_n;
      send(ALU_ADD, 3'd0, 5'd4, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t8_ready_async", 32'(req_ready_o), 32'd1);
      check("t8_vec_off", 32'(ex_vec_instr_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("t8_nwr", 32'(wr_n - wb), 32'd0);
      check("t8_no_done", 32'(done_n), 32'(d0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
